// File: rtl/lsu_byte_sequencer.sv
// lsu_byte_sequencer: splits CPU loads/stores (B/H/W, any alignment) into
// single-byte RAM accesses. Load bytes are assembled little-endian and then
// sign- or zero-extended. Each request gets one response pulse.
// Optional build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned H/HU/W
// requests are rejected with resp_error instead of being sequenced.
module lsu_byte_sequencer #(
   parameter int MEM_BYTES = 4096
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic        ram_load,
   output logic        ram_store,
   output logic [2:0]  ram_access,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_data_in,
   input  logic [31:0] ram_data_out
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESP} state_t;
   state_t state_reg, state_next;

   logic        we_reg;
   logic [2:0]  funct3_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [31:0] asm_reg;
   logic [31:0] resp_rdata_reg;
   logic        resp_error_reg;
   logic [2:0]  k_reg;

   logic        accept;
   logic        req_illegal;
   logic        last_byte;
   logic        cap_en;
   logic [1:0]  cap_idx;
   logic [2:0]  req_n;
   logic [2:0]  cur_n;
   logic [32:0] req_end;
   logic [31:0] asm_merged;
   logic        unused_ram_hi;

   // Byte count for a size code: 00 -> 1, 01 -> 2, 10 -> 4.
   function automatic logic [2:0] byte_count(input logic [1:0] size);
      case (size)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // Sign/zero extension of the assembled load word by funct3.
   function automatic logic [31:0] extend(input logic [31:0] a, input logic [2:0] f3);
      case (f3)
         3'b000:  return {{24{a[7]}}, a[7:0]};
         3'b001:  return {{16{a[15]}}, a[15:0]};
         3'b100:  return {24'd0, a[7:0]};
         3'b101:  return {16'd0, a[15:0]};
         default: return a;
      endcase
   endfunction

   assign unused_ram_hi = ^ram_data_out[31:8];

   assign cur_n      = byte_count(funct3_reg[1:0]);
   assign last_byte  = (k_reg == cur_n - 3'd1);
   assign cap_en     = ((state_reg == RUN) && !we_reg && (k_reg != 3'd0)) || (state_reg == DRAIN);
   assign cap_idx    = 2'(k_reg - 3'd1);
   assign ram_access = 3'b000;

   // Request legality; the end address is formed in 33 bits so a 32-bit wrap is rejected.
   always_comb begin
      req_n       = byte_count(req_funct3[1:0]);
      req_end     = {1'b0, req_addr} + {30'd0, req_n} - 33'd1;
      req_illegal = 1'b0;
      if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11)
         req_illegal = 1'b1;
      if (req_we && req_funct3[2])
         req_illegal = 1'b1;
      if (req_end >= 33'(MEM_BYTES))
         req_illegal = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
      if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
          (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00))
         req_illegal = 1'b1;
`endif
   end

   // Merge the byte returned by the RAM into its lane of the assembly word.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign asm_merged[8*gi +: 8] = (cap_en && cap_idx == 2'(gi)) ? ram_data_out[7:0]
                                                                      : asm_reg[8*gi +: 8];
      end
   endgenerate

   // RAM address/data are only driven while sequencing bytes.
   always_comb begin
      ram_addr    = 32'd0;
      ram_data_in = 32'd0;
      if (state_reg == RUN) begin
         ram_addr = addr_reg + {29'd0, k_reg};
         if (we_reg)
            ram_data_in = {24'd0, wdata_reg[{k_reg[1:0], 3'b000} +: 8]};
      end
   end

   // State register; reset aborts any sequence in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state and strobe decode.
   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      ram_load   = 1'b0;
      ram_store  = 1'b0;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept     = 1'b1;
               state_next = req_illegal ? RESP : RUN;
            end
         end
         RUN: begin
            ram_store = we_reg;
            ram_load  = !we_reg;
            if (last_byte)
               state_next = we_reg ? RESP : DRAIN;
         end
         DRAIN:   state_next = RESP;
         RESP: begin
            resp_valid = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request latch, byte counter, load assembly and response registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         we_reg         <= 1'b0;
         funct3_reg     <= 3'd0;
         addr_reg       <= 32'd0;
         wdata_reg      <= 32'd0;
         asm_reg        <= 32'd0;
         k_reg          <= 3'd0;
         resp_rdata_reg <= 32'd0;
         resp_error_reg <= 1'b0;
      end else begin
         if (accept) begin
            we_reg     <= req_we;
            funct3_reg <= req_funct3;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            k_reg      <= 3'd0;
            asm_reg    <= 32'd0;
            if (req_illegal) begin
               resp_rdata_reg <= 32'd0;
               resp_error_reg <= 1'b1;
            end
         end
         if (state_reg == RUN) begin
            k_reg   <= k_reg + 3'd1;
            asm_reg <= asm_merged;
            if (we_reg && last_byte) begin
               resp_rdata_reg <= 32'd0;
               resp_error_reg <= 1'b0;
            end
         end
         if (state_reg == DRAIN) begin
            asm_reg        <= asm_merged;
            resp_rdata_reg <= extend(asm_merged, funct3_reg);
            resp_error_reg <= 1'b0;
         end
      end
   end

   assign resp_rdata = resp_rdata_reg;
   assign resp_error = resp_error_reg;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Scoreboard bench for lsu_byte_sequencer: the stimulus pushes expected
// responses and RAM accesses; two monitors pop and compare on DUT activity.
module tb_lsu_byte_sequencer;
   localparam int MEM_BYTES = 4096;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic        ram_load;
   logic        ram_store;
   logic [2:0]  ram_access;
   logic [31:0] ram_addr;
   logic [31:0] ram_data_in;
   logic [31:0] ram_data_out;

   lsu_byte_sequencer #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
      .ram_load(ram_load), .ram_store(ram_store), .ram_access(ram_access),
      .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   always #5 clk = ~clk;

   // Byte RAM with one-cycle registered read; upper data bits carry junk.
   logic [7:0] mem [0:MEM_BYTES-1];
   always @(posedge clk) begin
      if (ram_store) mem[ram_addr[11:0]] <= ram_data_in[7:0];
      if (ram_load)  ram_data_out <= {24'hC3C3C3, mem[ram_addr[11:0]]};
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [31:0] rdata; logic err; int c0; int lat; string name; } resp_t;
   typedef struct { logic st; logic [31:0] addr; logic [7:0] data; int cyc; } acc_t;
   resp_t resp_q[$];
   acc_t  acc_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor.
   initial begin
      resp_t r;
      logic chk_ready_next;
      chk_ready_next = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            chk_ready_next = 1'b0;
         end else begin
            if (chk_ready_next) begin
               check("ready_after_resp", {31'd0, req_ready}, 32'd1);
               chk_ready_next = 1'b0;
            end
            if (resp_valid) begin
               if (resp_q.size() == 0) begin
                  check("resp_unexpected", {31'd0, resp_valid}, 32'd0);
               end else begin
                  r = resp_q.pop_front();
                  $display("resp %s: rdata=%h err=%b lat=%0d", r.name, resp_rdata, resp_error, cyc - r.c0);
                  check({r.name, "_rdata"}, resp_rdata, r.rdata);
                  check({r.name, "_err"}, {31'd0, resp_error}, {31'd0, r.err});
                  check({r.name, "_lat"}, 32'(cyc - r.c0), 32'(r.lat));
                  check({r.name, "_ready_low"}, {31'd0, req_ready}, 32'd0);
                  chk_ready_next = 1'b1;
               end
            end
         end
      end
   end

   // RAM access monitor.
   initial begin
      acc_t a;
      forever begin
         @(negedge clk);
         if (rstn && (ram_load || ram_store)) begin
            check("strobe_exclusive", {31'd0, ram_load & ram_store}, 32'd0);
            check("ram_access", {29'd0, ram_access}, 32'd0);
            if (acc_q.size() == 0) begin
               check("acc_unexpected", {30'd0, ram_load, ram_store}, 32'd0);
            end else begin
               a = acc_q.pop_front();
               check("acc_kind", {31'd0, ram_store}, {31'd0, a.st});
               check("acc_addr", ram_addr, a.addr);
               check("acc_cycle", 32'(cyc), 32'(a.cyc));
               if (a.st) check("acc_data", ram_data_in, {24'd0, a.data});
            end
         end
      end
   end

   task automatic wait_ready();
      int w = 0;
      @(negedge clk);
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) check("ready_timeout", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic wait_idle(input string name);
      int w = 0;
      while ((resp_q.size() != 0 || acc_q.size() != 0) && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (resp_q.size() != 0 || acc_q.size() != 0) begin
         check({name, "_done_timeout"}, 32'(resp_q.size() + acc_q.size()), 32'd0);
         resp_q.delete();
         acc_q.delete();
      end
   endtask

   // Drive one request; lat is the hand-computed response cycle after accept.
   task automatic issue(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat);
      resp_t r;
      acc_t  a;
      int    n;
      wait_ready();
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      r.rdata = exp_rdata; r.err = exp_err; r.c0 = cyc; r.lat = lat; r.name = name;
      resp_q.push_back(r);
      if (!exp_err) begin
         n = we ? lat - 1 : lat - 2;
         for (int i = 0; i < n; i++) begin
            a.st = we; a.addr = addr + 32'(i); a.data = wdata[8*i +: 8]; a.cyc = r.c0 + 1 + i;
            acc_q.push_back(a);
         end
      end
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = ~we;
      req_funct3 = 3'b111;
      req_addr   = 32'h5A5A_5A5A;
      req_wdata  = 32'hFFFF_FFFF;
      wait_idle(name);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
      check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      check({tag, "_resp_error"}, {31'd0, resp_error}, 32'd0);
      check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      check({tag, "_strobes"},    {30'd0, ram_load, ram_store}, 32'd0);
      check({tag, "_ram_addr"},   ram_addr, 32'd0);
      check({tag, "_ram_din"},    ram_data_in, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      acc_t a;
      int   c0;
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
      check_reset_state("reset");

      issue("sw_100",   1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 5);
      issue("lw_100",   1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 6);
      issue("lb_103",   1'b0, 3'b000, 32'h103, 32'h0,        32'hFFFFFFDE, 1'b0, 3);
      issue("lbu_103",  1'b0, 3'b100, 32'h103, 32'h0,        32'h000000DE, 1'b0, 3);
`ifdef LSU_MISALIGN_TRAP_EN
      issue("lh_101",   1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        1'b1, 1);
`else
      issue("lh_101",   1'b0, 3'b001, 32'h101, 32'h0,        32'hFFFFADBE, 1'b0, 4);
`endif
      issue("lhu_102",  1'b0, 3'b101, 32'h102, 32'h0,        32'h0000DEAD, 1'b0, 4);
      issue("sw_ffc",   1'b1, 3'b010, 32'hFFC, 32'h80706050, 32'h0,        1'b0, 5);
      issue("lw_ffd",   1'b0, 3'b010, 32'hFFD, 32'h0,        32'h0,        1'b1, 1);
      issue("lw_ffc",   1'b0, 3'b010, 32'hFFC, 32'h0,        32'h80706050, 1'b0, 6);
      issue("lb_fff",   1'b0, 3'b000, 32'hFFF, 32'h0,        32'hFFFFFF80, 1'b0, 3);
      issue("lh_ffe",   1'b0, 3'b001, 32'hFFE, 32'h0,        32'hFFFF8070, 1'b0, 4);
      issue("lhu_fff",  1'b0, 3'b101, 32'hFFF, 32'h0,        32'h0,        1'b1, 1);
      issue("f3_011",   1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b1, 1);
      issue("f3_110",   1'b0, 3'b110, 32'h100, 32'h0,        32'h0,        1'b1, 1);
      issue("f3_111",   1'b0, 3'b111, 32'h100, 32'h0,        32'h0,        1'b1, 1);
      issue("sb_f3_100",1'b1, 3'b100, 32'h100, 32'h11,       32'h0,        1'b1, 1);
      issue("sh_f3_101",1'b1, 3'b101, 32'h100, 32'h11,       32'h0,        1'b1, 1);
      issue("lw_wrap",  1'b0, 3'b010, 32'hFFFFFFFF, 32'h0,   32'h0,        1'b1, 1);
      issue("sb_0",     1'b1, 3'b000, 32'h0,   32'h123456A5, 32'h0,        1'b0, 2);
      issue("lb_0",     1'b0, 3'b000, 32'h0,   32'h0,        32'hFFFFFFA5, 1'b0, 3);
      issue("sh_0",     1'b1, 3'b001, 32'h0,   32'hAAAA1234, 32'h0,        1'b0, 3);
      issue("lhu_0",    1'b0, 3'b101, 32'h0,   32'h0,        32'h00001234, 1'b0, 4);
      issue("lw_0_err_clear",1'b0, 3'b010, 32'h1000, 32'h0,  32'h0,        1'b1, 1);
      issue("lh_0",     1'b0, 3'b001, 32'h0,   32'h0,        32'h00001234, 1'b0, 4);
`ifdef LSU_MISALIGN_TRAP_EN
      issue("sw_301",   1'b1, 3'b010, 32'h301, 32'hCAFEF00D, 32'h0,        1'b1, 1);
      issue("lw_301",   1'b0, 3'b010, 32'h301, 32'h0,        32'h0,        1'b1, 1);
`else
      issue("sw_301",   1'b1, 3'b010, 32'h301, 32'hCAFEF00D, 32'h0,        1'b0, 5);
      issue("lw_301",   1'b0, 3'b010, 32'h301, 32'h0,        32'hCAFEF00D, 1'b0, 6);
`endif

      // Reset in cycle 2 of an SW: only byte 0 reaches the RAM, no response.
      wait_ready();
      c0 = cyc;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h200; req_wdata = 32'h11223344;
      a.st = 1'b1; a.addr = 32'h200; a.data = 8'h44; a.cyc = c0 + 1;
      acc_q.push_back(a);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      check("rst_store_drop", {31'd0, ram_store}, 32'd0);
      check("rst_addr_drop", ram_addr, 32'd0);
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
      check_reset_state("rst_mid");
      repeat (8) @(negedge clk);
      wait_idle("rst_abort");
      issue("lb_200",   1'b0, 3'b000, 32'h200, 32'h0,        32'h00000044, 1'b0, 3);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
